// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: pipeline hazard controller (load-use stall, MDU wait, branch redirect flush) with stall/flush counters.
// Latency: lock/flush outputs are combinational from state and current inputs (0 cycles); counters update on the next edge.
// Backpressure: asserts PC/IF-ID/ID-EX locks to hold upstream stages; flushes override locks in the latches.
module pipeline_hazard_ctrl #(
    parameter int unsigned REDIRECT_CYC = 2,   // legal range 1..15
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_branch_taken_i,
    input  logic             ex_mdu_busy_i,
    input  logic             cnt_clr_i,
    output logic             pc_lock_o,
    output logic             if_id_lock_o,
    output logic             id_ex_lock_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        REDIRECT = 2'd2,
        ILLEGAL  = 2'd3
    } state_e;

    // Down-counter preload: remaining REDIRECT cycles after the branch cycle itself.
    localparam logic [3:0] RELOAD      = 4'(REDIRECT_CYC - 1);
    localparam bit         MULTI_REDIR = (REDIRECT_CYC > 1);

    state_e     state_q, state_d;
    logic [3:0] redir_cnt_q, redir_cnt_d;
    logic       luh;

    logic       pc_lock_c, if_id_lock_c, id_ex_lock_c;
    logic       if_id_flush_c, id_ex_flush_c;

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Load-use hazard: ID reads a register that the load in EX has not yet produced.
    always_comb begin
        luh = ex_mem_read_i && (ex_rd_i != 5'd0) &&
              ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
               (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
    end

    // Next-state and Mealy control outputs; branch beats MDU busy beats load-use.
    always_comb begin
        state_d       = state_q;
        redir_cnt_d   = redir_cnt_q;
        pc_lock_c     = 1'b0;
        if_id_lock_c  = 1'b0;
        id_ex_lock_c  = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;

        case (state_q)
            RUN, MDU_WAIT: begin
                if (ex_branch_taken_i) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    if (MULTI_REDIR) begin
                        state_d     = REDIRECT;
                        redir_cnt_d = RELOAD;
                    end else begin
                        state_d = RUN;
                    end
                end else if (ex_mdu_busy_i) begin
                    pc_lock_c    = 1'b1;
                    if_id_lock_c = 1'b1;
                    id_ex_lock_c = 1'b1;
                    state_d      = MDU_WAIT;
                end else if (luh) begin
                    // Hold fetch/decode and inject a bubble into EX for one cycle.
                    pc_lock_c     = 1'b1;
                    if_id_lock_c  = 1'b1;
                    id_ex_flush_c = 1'b1;
                    state_d       = RUN;
                end else begin
                    state_d = RUN;
                end
            end
            REDIRECT: begin
                // Wrong-path fetches keep being squashed; MDU busy and load-use are moot here.
                if_id_flush_c = 1'b1;
                if (ex_branch_taken_i) begin
                    id_ex_flush_c = 1'b1;
                    redir_cnt_d   = RELOAD;
                    state_d       = REDIRECT;
                end else begin
                    redir_cnt_d = redir_cnt_q - 4'd1;
                    // A zero count cannot occur normally; treat it as done rather than wrap.
                    state_d     = (redir_cnt_q <= 4'd1) ? RUN : REDIRECT;
                end
            end
            default: begin
                state_d     = RUN;
                redir_cnt_d = 4'd0;
            end
        endcase
    end

    // State and redirect down-counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            redir_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    // Saturating performance counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_lock_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (if_id_flush_o && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // Controls are gated by reset so the pipeline is released while reset is held.
    assign pc_lock_o     = rst_ni & pc_lock_c;
    assign if_id_lock_o  = rst_ni & if_id_lock_c;
    assign id_ex_lock_o  = rst_ni & id_ex_lock_c;
    assign if_id_flush_o = rst_ni & if_id_flush_c;
    assign id_ex_flush_o = rst_ni & id_ex_flush_c;
    assign state_o       = state_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int RC   = 2;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [4:0]    id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
    logic          id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0;
    logic          ex_mem_read_i = 1'b0, ex_branch_taken_i = 1'b0;
    logic          ex_mdu_busy_i = 1'b0, cnt_clr_i = 1'b0;
    logic          pc_lock_o, if_id_lock_o, id_ex_lock_o, if_id_flush_o, id_ex_flush_o;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=run, 1=waiting on MDU, 2=redirecting; left = redirect cycles remaining.
    int m_mode = 0;
    int m_left = 0;
    int m_stall = 0;
    int m_flush = 0;

    pipeline_hazard_ctrl #(.REDIRECT_CYC(RC), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_rd_i(ex_rd_i), .ex_mem_read_i(ex_mem_read_i),
        .ex_branch_taken_i(ex_branch_taken_i), .ex_mdu_busy_i(ex_mdu_busy_i),
        .cnt_clr_i(cnt_clr_i),
        .pc_lock_o(pc_lock_o), .if_id_lock_o(if_id_lock_o), .id_ex_lock_o(id_ex_lock_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
        .state_o(state_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit br, input bit busy, input bit mr, input int rd,
                          input int rs1, input bit u1, input int rs2, input bit u2, input bit clr);
        ex_branch_taken_i = br;
        ex_mdu_busy_i     = busy;
        ex_mem_read_i     = mr;
        ex_rd_i           = 5'(rd);
        id_rs1_i          = 5'(rs1);
        id_rs1_used_i     = u1;
        id_rs2_i          = 5'(rs2);
        id_rs2_used_i     = u2;
        cnt_clr_i         = clr;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock cycle: inputs already applied after a falling edge; check, then advance the model.
    task automatic cycle(input string tag);
        bit luh, e_pc, e_ifl, e_idl, e_iff, e_idf;
        #1;
        luh = ex_mem_read_i && (ex_rd_i != 0) &&
              ((id_rs1_used_i && id_rs1_i == ex_rd_i) || (id_rs2_used_i && id_rs2_i == ex_rd_i));
        {e_pc, e_ifl, e_idl, e_iff, e_idf} = '0;
        if (m_mode == 2) begin
            e_iff = 1;
            e_idf = ex_branch_taken_i;
        end else if (ex_branch_taken_i) begin
            e_iff = 1; e_idf = 1;
        end else if (ex_mdu_busy_i) begin
            e_pc = 1; e_ifl = 1; e_idl = 1;
        end else if (luh) begin
            e_pc = 1; e_ifl = 1; e_idf = 1;
        end
        chk({tag, ".pc_lock"},     pc_lock_o,     e_pc);
        chk({tag, ".if_id_lock"},  if_id_lock_o,  e_ifl);
        chk({tag, ".id_ex_lock"},  id_ex_lock_o,  e_idl);
        chk({tag, ".if_id_flush"}, if_id_flush_o, e_iff);
        chk({tag, ".id_ex_flush"}, id_ex_flush_o, e_idf);
        chk({tag, ".state"},       state_o,       m_mode);
        chk({tag, ".stall_cnt"},   stall_cnt_o,   m_stall);
        chk({tag, ".flush_cnt"},   flush_cnt_o,   m_flush);
        @(posedge clk_i);
        if (ex_branch_taken_i) begin
            m_mode = (RC > 1) ? 2 : 0;
            m_left = RC - 1;
        end else if (m_mode == 2) begin
            m_left--;
            if (m_left == 0) m_mode = 0;
        end else begin
            m_mode = ex_mdu_busy_i ? 1 : 0;
        end
        if (cnt_clr_i) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (e_pc  && m_stall < MAXC) m_stall++;
            if (e_iff && m_flush < MAXC) m_flush++;
        end
        @(negedge clk_i);
    endtask

    // Reset pulse between edges with hazard inputs active; everything must drop at once.
    task automatic reset_pulse(input string tag);
        rst_ni = 1'b0;
        set_in(1, 1, 1, 5, 5, 1, 5, 1, 0);
        m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
        #1;
        chk({tag, ".rst_pc_lock"},     pc_lock_o,     0);
        chk({tag, ".rst_if_id_lock"},  if_id_lock_o,  0);
        chk({tag, ".rst_id_ex_lock"},  id_ex_lock_o,  0);
        chk({tag, ".rst_if_id_flush"}, if_id_flush_o, 0);
        chk({tag, ".rst_id_ex_flush"}, id_ex_flush_o, 0);
        chk({tag, ".rst_state"},       state_o,       0);
        chk({tag, ".rst_stall_cnt"},   stall_cnt_o,   0);
        chk({tag, ".rst_flush_cnt"},   flush_cnt_o,   0);
        @(posedge clk_i);
        #1;
        chk({tag, ".rst_edge_state"},    state_o,       0);
        chk({tag, ".rst_edge_if_flush"}, if_id_flush_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle();
    endtask

    initial begin
        // Reset at time zero, then release.
        reset_pulse("init");

        // Load-use on rs1: one stall cycle.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle("clr1");
        set_in(0, 0, 1, 5, 5, 1, 0, 0, 0); cycle("luh_rs1");
        idle(); cycle("luh_after");
        chk("luh_stall_cnt", stall_cnt_o, 1);
        chk("luh_state", state_o, 0);

        // Same stimulus with rd=0 and with rs1 unused: no hazard.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle("clr2");
        set_in(0, 0, 1, 0, 0, 1, 0, 0, 0); cycle("luh_rd0");
        set_in(0, 0, 1, 5, 5, 0, 0, 0, 0); cycle("luh_unused");
        set_in(0, 0, 1, 7, 1, 1, 7, 1, 0); cycle("luh_rs2");
        idle(); cycle("luh_idle");
        chk("noluh_stall_cnt", stall_cnt_o, 1);

        // Taken branch: two flush cycles then back to run.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle("clr3");
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle("br_c0");
        idle(); cycle("br_c1");
        idle(); cycle("br_c2");
        chk("br_flush_cnt", flush_cnt_o, 2);
        chk("br_state", state_o, 0);

        // Branch again while redirecting reloads the countdown.
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle("rebr_c0");
        set_in(1, 1, 1, 3, 3, 1, 0, 0, 0); cycle("rebr_c1");
        idle(); cycle("rebr_c2");
        idle(); cycle("rebr_c3");

        // MDU busy for 4 cycles with load-use pending, then the load-use stall.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle("clr4");
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 1, 9, 9, 1, 0, 0, 0); cycle($sformatf("mdu_%0d", i));
        end
        set_in(0, 0, 1, 9, 9, 1, 0, 0, 0); cycle("mdu_luh");
        idle(); cycle("mdu_idle");
        chk("mdu_stall_cnt", stall_cnt_o, 5);

        // Branch, busy and load-use together: branch wins.
        set_in(1, 1, 1, 4, 4, 1, 4, 1, 0); cycle("all3");
        idle(); cycle("all3_c1");
        idle(); cycle("all3_c2");

        // Reset mid-redirect and mid-MDU-wait.
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle("pre_rst_br");
        reset_pulse("rst_redirect");
        idle(); cycle("post_rst1");
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0); cycle("pre_rst_mdu");
        reset_pulse("rst_mdu");
        idle(); cycle("post_rst2");

        // Saturation of both counters, then clear beating an increment.
        for (int i = 0; i < 20; i++) begin
            set_in(0, 1, 0, 0, 0, 0, 0, 0, 0); cycle($sformatf("sat_stall_%0d", i));
        end
        idle(); cycle("sat_idle");
        chk("sat_stall_cnt", stall_cnt_o, MAXC);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle("sat_br0");
        for (int i = 0; i < 20; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle($sformatf("sat_flush_%0d", i));
        end
        idle(); cycle("sat_fidle0");
        idle(); cycle("sat_fidle1");
        chk("sat_flush_cnt", flush_cnt_o, MAXC);
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 1); cycle("clr_vs_inc");
        idle(); cycle("clr_vs_inc_after");
        chk("clr_prio_stall", stall_cnt_o, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_pulse("rnd_rst");
            end
            set_in($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
            cycle($sformatf("rnd_%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
